// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyphs,
// blank code and the digit-index width helper.
package seven_seg_pkg;

    // Active-high glyphs, bit order g..a; inverted once at the decoder output.
    localparam logic [15:0][6:0] SEG_PATTERN = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    assign seg_n = ~SEG_PATTERN[value];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with tear-free frame loading.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 125000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef LEADING_ZERO_BLANK_EN
    input  logic                    lzb_en,
`endif
    output logic                    pending,
    output logic                    frame_start,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   scan_out
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic                    wrap_q;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   src_blank;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic                    disp_write;

    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [3:0]              sel_digit;
    logic [6:0]              sel_pat;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            wrap_q <= wrap;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
        end
    end

    // Handshake: load is a fire-and-forget one-cycle strobe with no ready;
    // pending reports that a frame waits in the shadow for the next wrap.
    // A load landing on the wrap cycle bypasses the shadow straight to display.
    assign src_digits = load ? digits_in : sh_digits;
    assign src_dp     = load ? dp_in     : sh_dp;
    assign src_blank  = load ? blank_in  : sh_blank;
    assign disp_write = wrap && (pending || load);

`ifdef LEADING_ZERO_BLANK_EN
    logic sh_lzb;
    logic src_lzb;

    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [4*NUM_DIGITS-1:0] d,
        input logic [NUM_DIGITS-1:0]   b
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (run && d[4*j +: 4] == 4'h0)
                m[j] = 1'b1;
            run = run && ((d[4*j +: 4] == 4'h0) || b[j]);
        end
        return m;
    endfunction

    assign src_lzb   = load ? lzb_en : sh_lzb;
    assign eff_blank = src_blank | (src_lzb ? lz_mask(src_digits, src_blank) : '0);

    always_ff @(posedge clk) begin
        if (reset)
            sh_lzb <= 1'b0;
        else if (load)
            sh_lzb <= lzb_en;
    end
`else
    assign eff_blank = src_blank;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '1;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_blank  <= '1;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
            end
            if (disp_write) begin
                disp_digits <= src_digits;
                disp_dp     <= src_dp;
                disp_blank  <= eff_blank;
                pending     <= 1'b0;
            end else if (load) begin
                pending     <= 1'b1;
            end
        end
    end

    assign sel_digit = disp_digits[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .value (sel_digit),
        .seg_n (sel_pat)
    );

    // Outputs trail idx by one cycle; frame_start is timed to match scan_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out     <= SEG_BLANK;
            scan_out    <= ~NUM_DIGITS'(1);
            frame_start <= 1'b0;
        end else begin
            seg_out     <= disp_blank[idx] ? SEG_BLANK : {~disp_dp[idx], sel_pat};
            scan_out    <= ~(NUM_DIGITS'(1) << idx);
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NUM_DIGITS=4, SCAN_DIV=4.
// Covers LEADING_ZERO_BLANK_EN behaviour when that macro is defined.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] blank_in;
`ifdef LEADING_ZERO_BLANK_EN
    logic          lzb_en;
`endif
    logic          pending;
    logic          frame_start;
    logic [7:0]    seg_out;
    logic [ND-1:0] scan_out;

    int tests = 0;
    int fails = 0;

    seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
`ifdef LEADING_ZERO_BLANK_EN
        .lzb_en      (lzb_en),
`endif
        .pending     (pending),
        .frame_start (frame_start),
        .seg_out     (seg_out),
        .scan_out    (scan_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_en    = lz;
`endif
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (lz) digits_in = 16'hFFFF; // scramble inputs after the strobe
        else    digits_in = 16'hEEEE;
    endtask

    task automatic wait_frame_start(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL frame_start_timeout: observed none expected pulse within %0d cycles", budget);
        end
    endtask

    // Starts on the frame_start cycle; ends on the next frame's first cycle.
    task automatic check_frame(input string tag, input logic [3:0][7:0] exp_seg);
        logic [3:0] exp_scan;
        for (int d = 0; d < ND; d++) begin
            exp_scan = ~(4'b0001 << d);
            for (int k = 0; k < SD; k++) begin
                chk({tag, "_scan"}, 16'(scan_out), 16'(exp_scan));
                chk({tag, "_seg"},  16'(seg_out),  16'(exp_seg[d]));
                chk({tag, "_fs"},   16'(frame_start), 16'(d == 0 && k == 0));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_in  = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_en    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_scan",    16'(scan_out), 16'h000E);
        chk("rst_seg",     16'(seg_out), 16'h00FF);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_fs",      16'(frame_start), 16'h0);

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_fs", 16'(frame_start), 16'h0);
        end
        wait_frame_start(40);
        check_frame("blank_frame", {8'hFF, 8'hFF, 8'hFF, 8'hFF});

        // Load 4,3,2,1 while idx=1.
        repeat (4) @(negedge clk);
        do_load(16'h4321, 4'b0000, 4'b0000, 1'b0);
        chk("load_pending", 16'(pending), 16'h1);
        chk("load_old_seg", 16'(seg_out), 16'h00FF);
        chk("load_scan",    16'(scan_out), 16'h000D);
        wait_frame_start(40);
        chk("wrap_pending", 16'(pending), 16'h0);
        check_frame("frame_4321", {8'h99, 8'hB0, 8'hA4, 8'hF9});
        chk("frame_period", 16'(frame_start), 16'h1);
        check_frame("frame_4321_b", {8'h99, 8'hB0, 8'hA4, 8'hF9});

        // Two loads in one frame: last one wins.
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        do_load(16'h8888, 4'b0000, 4'b0000, 1'b0);
        chk("double_pending", 16'(pending), 16'h1);
        wait_frame_start(40);
        check_frame("frame_8888", {8'h80, 8'h80, 8'h80, 8'h80});

        // Load on the wrap cycle (idx=3, cnt=3) takes the bypass path.
        chk("bypass_fs", 16'(frame_start), 16'h1);
        repeat (14) @(negedge clk);
        do_load(16'h0000, 4'b0001, 4'b0000, 1'b0);
        chk("bypass_pending", 16'(pending), 16'h0);
        wait_frame_start(2);
        check_frame("frame_bypass", {8'hC0, 8'hC0, 8'hC0, 8'h40});

        // Reset while a frame is pending.
        repeat (5) @(negedge clk);
        do_load(16'h7777, 4'b0000, 4'b0000, 1'b0);
        chk("pre_rst_pending", 16'(pending), 16'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_pending", 16'(pending), 16'h0);
        chk("mid_rst_scan",    16'(scan_out), 16'h000E);
        chk("mid_rst_seg",     16'(seg_out), 16'h00FF);
        chk("mid_rst_fs",      16'(frame_start), 16'h0);
        reset = 1'b0;
        wait_frame_start(40);
        check_frame("after_rst_a", {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        check_frame("after_rst_b", {8'hFF, 8'hFF, 8'hFF, 8'hFF});

`ifdef LEADING_ZERO_BLANK_EN
        // Digits 3..0 = 0,0,5,0; dp on digit 3 must stay dark too.
        do_load(16'h0050, 4'b1000, 4'b0000, 1'b1);
        wait_frame_start(40);
        check_frame("lzb_frame", {8'hFF, 8'hFF, 8'h92, 8'hC0});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised multiplexed seven-segment driver: NUM_DIGITS digits, each showing an independent hex value with decimal point and blanking.
- Scan rate comes from an internal clock-enable divider; no derived clocks.
- Host loads a full frame with a one-cycle pulse. The frame is applied only at the scan-frame boundary, so the display never tears.
- Sits between counter/display logic and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 8, digit count, legal 2..16
SCAN_DIV, 125000, clk cycles per digit slot, legal >= 2
CNT_W, $clog2(SCAN_DIV), divider width (derived, not overridden)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; captures digits_in, dp_in, blank_in
digits_in  in  4*NUM_DIGITS  nibble i = digit i value 0..F
dp_in  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i
blank_in  in  NUM_DIGITS  bit i = 1 forces digit i dark
pending  out  1  high while a loaded frame waits for the boundary
frame_start  out  1  one-cycle pulse when digit 0 becomes active
seg_out  out  8  active-low segments; [7]=dp, [6:0]=g..a
scan_out  out  NUM_DIGITS  active-low one-hot anode select

Behaviour:
- Only clk is used; every register resets synchronously when reset=1 at a clk edge.
- Reset values:
  - divider=0, idx=0, pending=0, frame_start=0
  - shadow and display registers: digits=0, dp=0, blank=all ones
  - seg_out=8'hFF; scan_out = all ones except bit0=0
- Divider:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 in the cycle where cnt==SCAN_DIV-1.
- Digit index:
  - On tick, idx advances by 1; from NUM_DIGITS-1 it wraps to 0.
  - wrap = tick && idx==NUM_DIGITS-1.
- Load handshake:
  - load=1 writes shadow from the inputs and sets pending=1 next cycle.
  - load while pending overwrites shadow; last load wins; no error.
  - On wrap with pending=1, display <= shadow and pending <= 0.
  - load and wrap in the same cycle: display <= the inputs directly (bypass) and pending <= 0.
  - On wrap with pending=0, display is unchanged.
- Outputs: registered, updated every cycle from idx and the display registers, so they lag idx by one cycle. seg_out and scan_out always change on the same edge.
  - scan_out = ~(1 << idx).
  - seg_out when blank[idx]=1: 8'hFF.
  - seg_out otherwise: {~dp[idx], pattern(digit[idx])}.
  - Patterns with dp bit set (hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 98, A 88, b 83, C C6, d A1, E 86, F 8E.
- frame_start:
  - Registered pulse, high for one cycle on the same edge that scan_out first shows digit 0 of a new frame.
  - Not asserted in the first post-reset cycles.
- Reset mid-frame: pending is discarded; the display returns to blank and digit 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Adds input lzb_en (1 bit), sampled with load into shadow.
  - When the effective lzb_en=1, any digit j whose value is 0 is blanked if every digit with index > j is also 0 or blanked. Index NUM_DIGITS-1 is the most significant digit.
  - Digit 0 is never blanked by this rule.
  - The dp of a digit blanked by this rule is also dark.
  - The blanking mask is computed when display is written, not per scan slot.
- Undefined: no lzb_en port; zeros always display.

Decomposition:
- Package seven_seg_pkg:
  - seg pattern constant array (16 x 7 bits, active-high form inverted at output)
  - SEG_BLANK=8'hFF
  - digit index width function
- Sub-module seg_hex_decode: combinational 4-bit value to 7-bit active-low pattern, instanced once on the selected digit.

Test Plan:
- Setup for all scenarios: NUM_DIGITS=4, SCAN_DIV=4.
- Reset release: scan_out=4'b1110 and seg_out=FF while reset; digits stay blank until the first load.
- Load digits 3,2,1,0 = 4,3,2,1 with blank=0 at idx=1:
  - pending=1 until the next wrap.
  - Then slots show F9, A4, B0, 99 on digit 0..3, each 4 cycles.
  - frame_start pulses once per 16 cycles.
- Two loads within one frame (values 1 then 8 on all digits): after the wrap all digits show 80; the first value never appears.
- Load coincident with wrap (dp_in=4'b0001, digits=0): digit 0 shows 40 in the very next frame; pending stays 0.
- Reset asserted while pending=1 mid-frame: pending=0; outputs return to the reset values; the old shadow is never displayed.
- LEADING_ZERO_BLANK_EN with digits 0,0,5,0 and lzb_en=1: digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0.
